// File: rtl/approx_eval_pkg.sv
// Shared definitions for the approximate-circuit evaluators: FSM state codes
// and width helpers derived from the circuit's input/output counts.
package approx_eval_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic int nvec(input int n_in);
    return 2 ** n_in;
  endfunction

  function automatic int sum_w(input int n_in, input int n_out);
    return n_in + n_out;
  endfunction

  function automatic int cnt_w(input int n_in);
    return n_in + 1;
  endfunction

endpackage

// File: rtl/approx_err_calc.sv
// Splits a stimulus vector into adder operands, forms the exact sum and the
// absolute error of the approximate result. Swap the reference to reuse it.
module approx_err_calc
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic [N_IN-1:0]  vec,
  input  logic [N_OUT-1:0] approx,
  output logic [N_OUT-1:0] exact,
  output logic [N_OUT-1:0] d
);

  localparam int H = N_IN / 2;

  logic [H-1:0] op_a;
  logic [H-1:0] op_b;

  assign op_a  = vec[H-1:0];
  assign op_b  = vec[N_IN-1:H];
  assign exact = N_OUT'(op_a) + N_OUT'(op_b);
  assign d     = (approx >= exact) ? (approx - exact) : (exact - approx);

endmodule

// File: rtl/approx_adder_error_sweeper.sv
// Exhaustively drives an approximate adder, compares each output with the
// exact sum two stages later, and accumulates error statistics.
module approx_adder_error_sweeper
  import approx_eval_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int ET    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       dut_in,
  input  logic [N_OUT-1:0]      dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_IN-1:0]       worst_vec,
  output logic [N_IN:0]         err_cnt,
  output logic [N_IN+N_OUT-1:0] err_sum,
  output logic                  pass
);

  localparam int SUM_W = sum_w(N_IN, N_OUT);
  localparam int CNT_W = cnt_w(N_IN);
  localparam logic [N_OUT-1:0] ET_W = N_OUT'(ET);

  logic [1:0]       state;
  logic             s1_valid;
  logic [N_IN-1:0]  s1_vec;
  logic [N_OUT-1:0] s1_out;
  logic [N_OUT-1:0] exact;
  logic [N_OUT-1:0] d;

  approx_err_calc #(
    .N_IN (N_IN),
    .N_OUT(N_OUT)
  ) u_calc (
    .vec   (s1_vec),
    .approx(s1_out),
    .exact (exact),
    .d     (d)
  );

  // Start clears happen after the accumulate; s1_valid is always low then anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      max_err   <= '0;
      worst_vec <= '0;
      err_cnt   <= '0;
      err_sum   <= '0;
      s1_valid  <= 1'b0;
      s1_vec    <= '0;
      s1_out    <= '0;
    end else begin
      s1_valid <= (state == SWEEP);
      s1_vec   <= dut_in;
      s1_out   <= dut_out;

      if (s1_valid) begin
        err_sum <= err_sum + SUM_W'(d);
        if (s1_out != exact) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        if (d > max_err) begin
          max_err   <= d;
          worst_vec <= s1_vec;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= SWEEP;
            dut_in    <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            max_err   <= '0;
            worst_vec <= '0;
            err_cnt   <= '0;
            err_sum   <= '0;
          end
        end
        SWEEP: begin
          // The last vector stays on dut_in one more cycle so S1 can capture it.
          if (&dut_in) begin
            state <= DRAIN;
          end else begin
            dut_in <= dut_in + N_IN'(1);
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (max_err <= ET_W);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
